// File: rtl/cpu_reset_seq.sv
// 6502 clock/reset sequencer: phi2 = clk_2/2, PLL reset, button debounce, clean cpu_resb.
// All outputs registered; lock/button see 2-cycle sync latency; no backpressure (free-running).
module cpu_reset_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_PHI2       = 8,
  parameter int PLL_RST_CYCLES  = 4
) (
  input  logic clk_2,
  input  logic resetb,
  input  logic button_reset,
  input  logic pll_cpu_locked,
  output logic cpu_phi2,
  output logic cpu_resb,
  output logic pll_cpu_reset,
  output logic reset_active
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW  = (HOLD_PHI2 > 1) ? $clog2(HOLD_PHI2) : 1;
  localparam int PW  = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_PHI2 - 1);
  localparam logic [PW-1:0]  PLL_LAST  = PW'(PLL_RST_CYCLES - 1);

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, HOLD, RUN} state_t;

  logic           btn_m, btn_s, lock_m, lock_s;
  logic           btn_db;
  logic [DBW-1:0] db_cnt;
  state_t         state, state_nxt;
  logic [PW-1:0]  pll_cnt, pll_cnt_nxt;
  logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
  logic           resb_nxt, pll_rst_nxt;
  logic           phi2_fall;

  always_ff @(posedge clk_2 or negedge resetb) begin
    if (!resetb) begin
      btn_m  <= 1'b1;
      btn_s  <= 1'b1;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      btn_m  <= button_reset;
      btn_s  <= btn_m;
      lock_m <= pll_cpu_locked;
      lock_s <= lock_m;
    end
  end

  // Debounced state only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk_2 or negedge resetb) begin
    if (!resetb) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_2 or negedge resetb) begin
    if (!resetb) cpu_phi2 <= 1'b0;
    else         cpu_phi2 <= ~cpu_phi2;
  end

  assign phi2_fall = cpu_phi2;

  always_ff @(posedge clk_2 or negedge resetb) begin
    if (!resetb) begin
      state         <= PLL_RST;
      pll_cnt       <= '0;
      hold_cnt      <= '0;
      cpu_resb      <= 1'b0;
      pll_cpu_reset <= 1'b0;
      reset_active  <= 1'b1;
    end else begin
      state         <= state_nxt;
      pll_cnt       <= pll_cnt_nxt;
      hold_cnt      <= hold_cnt_nxt;
      cpu_resb      <= resb_nxt;
      pll_cpu_reset <= pll_rst_nxt;
      reset_active  <= (state_nxt != RUN);
    end
  end

  always_comb begin
    state_nxt    = state;
    pll_cnt_nxt  = pll_cnt;
    hold_cnt_nxt = hold_cnt;
    resb_nxt     = 1'b0;
    pll_rst_nxt  = pll_cpu_reset;
    case (state)
      PLL_RST: begin
        if (pll_cnt == PLL_LAST) begin
          pll_rst_nxt = 1'b1;
          state_nxt   = WAIT_LOCK;
        end else begin
          pll_cnt_nxt = pll_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
        end
      end
      HOLD: begin
        // cpu_resb may only release on a phi2 fall, so RUN is entered only there.
        if (!lock_s) begin
          state_nxt    = WAIT_LOCK;
          hold_cnt_nxt = '0;
        end else if (!btn_db) begin
          hold_cnt_nxt = '0;
        end else if (phi2_fall) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = RUN;
            resb_nxt  = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        resb_nxt = 1'b1;
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          resb_nxt  = 1'b0;
        end else if (!btn_db) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
          resb_nxt     = 1'b0;
        end
      end
      default: state_nxt = PLL_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Directed bench for cpu_reset_seq: stimulus queues expected output edges/levels, a negedge monitor checks them.
module tb_cpu_reset_seq;

  logic clk_2 = 1'b0;
  logic resetb = 1'b0;
  logic button_reset = 1'b1;
  logic pll_cpu_locked = 1'b1;
  logic cpu_phi2, cpu_resb, pll_cpu_reset, reset_active;
  logic [3:0] outs;

  cpu_reset_seq #(
    .DEBOUNCE_CYCLES(16),
    .HOLD_PHI2(8),
    .PLL_RST_CYCLES(4)
  ) dut (
    .clk_2(clk_2),
    .resetb(resetb),
    .button_reset(button_reset),
    .pll_cpu_locked(pll_cpu_locked),
    .cpu_phi2(cpu_phi2),
    .cpu_resb(cpu_resb),
    .pll_cpu_reset(pll_cpu_reset),
    .reset_active(reset_active)
  );

  always #5 clk_2 = ~clk_2;

  int cyc = 0;
  always @(posedge clk_2) cyc <= cyc + 1;

  assign outs = {cpu_phi2, cpu_resb, pll_cpu_reset, reset_active};

  // kind: 0 = cpu_resb fall, 1 = cpu_resb rise (must coincide with phi2 1->0), 2 = pll_cpu_reset rise
  typedef struct { int kind; int lo; int hi; } ev_t;
  // level snapshot of {phi2, resb, pll, active} at the negedge of cycle 'at'
  typedef struct { int id; int at; logic [3:0] val; logic [3:0] mask; } lvl_t;

  ev_t  ev[$];
  lvl_t lv[$];
  int   timeouts = 0;
  bit   done = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #2;
  endtask

  task automatic push_ev(input int k, input int lo, input int hi);
    ev_t e;
    e.kind = k; e.lo = lo; e.hi = hi;
    ev.push_back(e);
  endtask

  task automatic push_lv(input int id, input logic [3:0] val, input logic [3:0] mask);
    lvl_t l;
    l.id = id; l.at = cyc; l.val = val; l.mask = mask;
    lv.push_back(l);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && ev.size() != 0; i++) @(posedge clk_2);
    if (ev.size() != 0) begin
      timeouts = timeouts + 1;
      ev.delete();
    end
    tick(2);
  endtask

  // Monitor / scoreboard: sole owner of the check counters.
  initial begin : monitor
    int checks, failures, phi2_err, act_err;
    logic prev_resb, prev_pll, prev_phi2, prev_rstb;
    lvl_t l;
    ev_t e;
    int k;
    checks = 0; failures = 0; phi2_err = 0; act_err = 0;
    prev_resb = 1'b0; prev_pll = 1'b0; prev_phi2 = 1'b0; prev_rstb = 1'b0;
    forever begin
      @(negedge clk_2);
      while (lv.size() > 0 && lv[0].at <= cyc) begin
        l = lv.pop_front();
        checks++;
        if (l.at != cyc || ((outs ^ l.val) & l.mask) != 4'b0) begin
          failures++;
          $display("FAIL level_%0d cyc=%0d got={phi2,resb,pll,act}=%b want=%b mask=%b",
                   l.id, cyc, outs, l.val, l.mask);
        end
      end
      for (int j = 0; j < 2; j++) begin
        k = -1;
        if (resetb && j == 0 && cpu_resb != prev_resb) k = cpu_resb ? 1 : 0;
        if (resetb && j == 1 && pll_cpu_reset && !prev_pll) k = 2;
        if (k >= 0) begin
          checks++;
          if (ev.size() == 0) begin
            failures++;
            $display("FAIL unexpected_edge kind=%0d cyc=%0d (no edge expected)", k, cyc);
          end else begin
            e = ev.pop_front();
            if (e.kind != k || cyc < e.lo || cyc > e.hi || (k == 1 && cpu_phi2 != 1'b0)) begin
              failures++;
              $display("FAIL edge kind=%0d got cyc=%0d phi2=%b, want kind=%0d cyc=%0d..%0d",
                       k, cyc, cpu_phi2, e.kind, e.lo, e.hi);
            end
          end
        end
      end
      if (resetb && prev_rstb && cpu_phi2 == prev_phi2) phi2_err++;
      if (reset_active == cpu_resb) act_err++;
      prev_resb = cpu_resb; prev_pll = pll_cpu_reset;
      prev_phi2 = cpu_phi2; prev_rstb = resetb;
      if (done) begin
        checks++;
        if (phi2_err != 0) begin
          failures++;
          $display("FAIL phi2_period bad_cycles=%0d want 0", phi2_err);
        end
        checks++;
        if (act_err != 0) begin
          failures++;
          $display("FAIL reset_active_vs_resb bad_cycles=%0d want 0", act_err);
        end
        checks++;
        if (timeouts != 0 || ev.size() != 0 || lv.size() != 0) begin
          failures++;
          $display("FAIL scoreboard_drain timeouts=%0d left_ev=%0d left_lv=%0d want 0/0/0",
                   timeouts, ev.size(), lv.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin : stim
    int base, p;
    // Power-up: resetb low 5 cycles, lock steady high, button released.
    tick(1);
    push_lv(0, 4'b0001, 4'b1111);
    tick(4);
    push_lv(1, 4'b0001, 4'b1111);
    tick(1);
    resetb = 1'b1;
    base = cyc;
    push_ev(2, base + 4, base + 4);
    push_ev(1, base + 20, base + 21);
    wait_drain(60);

    // Glitch rejection: 10-cycle press must not reach cpu_resb.
    button_reset = 1'b0;
    tick(10);
    button_reset = 1'b1;
    tick(30);
    push_lv(2, 4'b0110, 4'b0111);
    tick(2);

    // Button press held 40 cycles.
    p = cyc;
    button_reset = 1'b0;
    push_ev(0, p + 19, p + 19);
    push_ev(1, p + 73, p + 74);
    tick(40);
    button_reset = 1'b1;
    wait_drain(80);

    // One-cycle lock loss in RUN.
    p = cyc;
    pll_cpu_locked = 1'b0;
    push_ev(0, p + 3, p + 3);
    push_ev(1, p + 19, p + 20);
    tick(1);
    pll_cpu_locked = 1'b1;
    wait_drain(40);
    push_lv(3, 4'b0010, 4'b0010);
    tick(2);

    // Lock loss to reach HOLD, then resetb asserted after 5 phi2 falls there.
    p = cyc;
    pll_cpu_locked = 1'b0;
    push_ev(0, p + 3, p + 3);
    tick(1);
    pll_cpu_locked = 1'b1;
    tick(13);
    resetb = 1'b0;
    push_lv(4, 4'b0001, 4'b1111);
    tick(5);
    resetb = 1'b1;
    base = cyc;
    push_ev(2, base + 4, base + 4);
    push_ev(1, base + 20, base + 21);
    wait_drain(60);

    // Button held through a lock loss: no counting in HOLD until debounced high.
    p = cyc;
    button_reset = 1'b0;
    push_ev(0, p + 19, p + 19);
    push_ev(1, p + 93, p + 94);
    tick(20);
    pll_cpu_locked = 1'b0;
    tick(1);
    pll_cpu_locked = 1'b1;
    tick(39);
    button_reset = 1'b1;
    wait_drain(80);

    done = 1'b1;
  end

endmodule
